// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use, multi-cycle mul, taken-branch and stop/drain.
// Outputs are Mealy (combinational from state, counter and inputs) so hazards act in the cycle they appear.
module pipe_hazard_ctrl #(
    parameter int unsigned MUL_STALL = 2,
    parameter int unsigned DRAIN_CYC = 3,
    parameter int unsigned CNT_W     = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [4:0] ID_rs1_i,
    input  logic [4:0] ID_rs2_i,
    input  logic [4:0] EX_rd_i,
    input  logic       EX_MemRead_i,
    input  logic       EX_mul_i,
    input  logic       branch_taken_i,
    output logic       PCWrite_o,
    output logic       PCSrc_o,
    output logic       IFIDWrite_o,
    output logic       IFIDFlush_o,
    output logic       IDEXWrite_o,
    output logic       IDEXBubble_o,
    output logic       EXMEMBubble_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_MUL_WAIT = 2'd2,
        S_DRAIN    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MUL_LOAD   = CNT_W'(MUL_STALL - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYC - 1);
    localparam logic             MUL_EN     = (MUL_STALL != 0);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_load_use;
    logic             w_cnt_zero;

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign w_load_use = EX_MemRead_i && (EX_rd_i != 5'd0) &&
                        ((EX_rd_i == ID_rs1_i) || (EX_rd_i == ID_rs2_i));
    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        PCWrite_o     = 1'b1;
        PCSrc_o       = 1'b0;
        IFIDWrite_o   = 1'b1;
        IFIDFlush_o   = 1'b0;
        IDEXWrite_o   = 1'b1;
        IDEXBubble_o  = 1'b0;
        EXMEMBubble_o = 1'b0;
        busy_o        = (r_state != S_IDLE);

        unique case (r_state)
            S_IDLE: begin
                PCWrite_o    = 1'b0;
                IFIDWrite_o  = 1'b0;
                IFIDFlush_o  = 1'b1;
                IDEXBubble_o = 1'b1;
                if (start_i) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!start_i) begin
                    PCWrite_o    = 1'b0;
                    IFIDWrite_o  = 1'b0;
                    IFIDFlush_o  = 1'b1;
                    IDEXBubble_o = 1'b1;
                    w_cnt_nxt    = DRAIN_LOAD;
                    w_state_nxt  = S_DRAIN;
                end else if (EX_mul_i && MUL_EN) begin
                    PCWrite_o     = 1'b0;
                    IFIDWrite_o   = 1'b0;
                    IDEXWrite_o   = 1'b0;
                    EXMEMBubble_o = 1'b1;
                    w_cnt_nxt     = MUL_LOAD;
                    w_state_nxt   = S_MUL_WAIT;
                end else if (w_load_use) begin
                    // branch in ID is held back and re-resolves once the load clears
                    PCWrite_o    = 1'b0;
                    IFIDWrite_o  = 1'b0;
                    IDEXBubble_o = 1'b1;
                end else if (branch_taken_i) begin
                    PCSrc_o     = 1'b1;
                    IFIDFlush_o = 1'b1;
                end
            end
            S_MUL_WAIT: begin
                if (!w_cnt_zero) begin
                    PCWrite_o     = 1'b0;
                    IFIDWrite_o   = 1'b0;
                    IDEXWrite_o   = 1'b0;
                    EXMEMBubble_o = 1'b1;
                    w_cnt_nxt     = r_cnt - CNT_W'(1);
                end else begin
                    // release cycle: the mul leaves EX, so EX_mul_i here is stale
                    w_state_nxt = S_RUN;
                    if (w_load_use) begin
                        PCWrite_o    = 1'b0;
                        IFIDWrite_o  = 1'b0;
                        IDEXBubble_o = 1'b1;
                    end else if (branch_taken_i) begin
                        PCSrc_o     = 1'b1;
                        IFIDFlush_o = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                PCWrite_o    = 1'b0;
                IFIDWrite_o  = 1'b0;
                IFIDFlush_o  = 1'b1;
                IDEXBubble_o = 1'b1;
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations plus random traffic
// checked every cycle against a cycle-count reference model, on a default and a no-mul-stall instance.
module tb_pipe_hazard_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [4:0] ID_rs1_i, ID_rs2_i, EX_rd_i;
    logic       EX_MemRead_i, EX_mul_i, branch_taken_i;

    logic a_pcw, a_pcs, a_ifw, a_iff, a_idw, a_idb, a_exb, a_busy;
    logic b_pcw, b_pcs, b_ifw, b_iff, b_idw, b_idb, b_exb, b_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    pipe_hazard_ctrl #(.MUL_STALL(2), .DRAIN_CYC(3), .CNT_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i), .EX_rd_i(EX_rd_i),
        .EX_MemRead_i(EX_MemRead_i), .EX_mul_i(EX_mul_i), .branch_taken_i(branch_taken_i),
        .PCWrite_o(a_pcw), .PCSrc_o(a_pcs), .IFIDWrite_o(a_ifw), .IFIDFlush_o(a_iff),
        .IDEXWrite_o(a_idw), .IDEXBubble_o(a_idb), .EXMEMBubble_o(a_exb), .busy_o(a_busy)
    );

    pipe_hazard_ctrl #(.MUL_STALL(0), .DRAIN_CYC(1), .CNT_W(4)) dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i), .EX_rd_i(EX_rd_i),
        .EX_MemRead_i(EX_MemRead_i), .EX_mul_i(EX_mul_i), .branch_taken_i(branch_taken_i),
        .PCWrite_o(b_pcw), .PCSrc_o(b_pcs), .IFIDWrite_o(b_ifw), .IFIDFlush_o(b_iff),
        .IDEXWrite_o(b_idw), .IDEXBubble_o(b_idb), .EXMEMBubble_o(b_exb), .busy_o(b_busy)
    );

    // Output vectors {PCWrite,PCSrc,IFIDWrite,IFIDFlush,IDEXWrite,IDEXBubble,EXMEMBubble,busy}
    localparam logic [7:0] O_IDLE  = 8'b0001_1100;
    localparam logic [7:0] O_RUN   = 8'b1010_1001;
    localparam logic [7:0] O_MUL   = 8'b0000_0011;
    localparam logic [7:0] O_LU    = 8'b0000_1101;
    localparam logic [7:0] O_BR    = 8'b1111_1001;
    localparam logic [7:0] O_DRAIN = 8'b0001_1101;

    localparam int M_IDLE = 0, M_RUN = 1, M_MUL = 2, M_REL = 3, M_DRAIN = 4;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Reference: mode plus "cycles still to spend" in that mode
    function automatic void model_eval(input int mode, input int left, input int ms, input int dc,
                                       input logic st, input logic lu, input logic ml, input logic br,
                                       output logic [7:0] o, output int nm, output int nl);
        nm = mode;
        nl = left;
        o  = O_RUN;
        case (mode)
            M_IDLE: begin
                o = O_IDLE;
                if (st) nm = M_RUN;
            end
            M_RUN: begin
                if (!st) begin
                    o = O_DRAIN; nm = M_DRAIN; nl = dc;
                end else if (ml && ms > 0) begin
                    o = O_MUL;
                    if (ms > 1) begin nm = M_MUL; nl = ms - 1; end
                    else nm = M_REL;
                end else if (lu) o = O_LU;
                else if (br) o = O_BR;
            end
            M_MUL: begin
                o = O_MUL;
                if (left > 1) nl = left - 1;
                else nm = M_REL;
            end
            M_REL: begin
                nm = M_RUN;
                if (lu) o = O_LU;
                else if (br) o = O_BR;
            end
            default: begin
                o = O_DRAIN;
                if (left > 1) nl = left - 1;
                else nm = M_IDLE;
            end
        endcase
    endfunction

    logic       lu;
    logic [7:0] exp_a, exp_b;
    int         ma_mode, ma_left, mb_mode, mb_left;
    int         na_mode, na_left, nb_mode, nb_left;

    always_comb begin
        lu = EX_MemRead_i && (EX_rd_i != 5'd0) && (EX_rd_i == ID_rs1_i || EX_rd_i == ID_rs2_i);
        model_eval(ma_mode, ma_left, 2, 3, start_i, lu, EX_mul_i, branch_taken_i, exp_a, na_mode, na_left);
        model_eval(mb_mode, mb_left, 0, 1, start_i, lu, EX_mul_i, branch_taken_i, exp_b, nb_mode, nb_left);
    end

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ma_mode <= M_IDLE; ma_left <= 0;
            mb_mode <= M_IDLE; mb_left <= 0;
        end else begin
            ma_mode <= na_mode; ma_left <= na_left;
            mb_mode <= nb_mode; mb_left <= nb_left;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk_i) begin
        chk("model_main", {a_pcw, a_pcs, a_ifw, a_iff, a_idw, a_idb, a_exb, a_busy}, exp_a);
        chk("model_nomul", {b_pcw, b_pcs, b_ifw, b_iff, b_idw, b_idb, b_exb, b_busy}, exp_b);
    end

    task automatic cyc(input logic s, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic mr, input logic ml, input logic br);
        @(posedge clk_i);
        #1;
        start_i = s; ID_rs1_i = r1; ID_rs2_i = r2; EX_rd_i = rd;
        EX_MemRead_i = mr; EX_mul_i = ml; branch_taken_i = br;
        #2;
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0; ID_rs1_i = '0; ID_rs2_i = '0; EX_rd_i = '0;
        EX_MemRead_i = 1'b0; EX_mul_i = 1'b0; branch_taken_i = 1'b0;

        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("reset_busy", {7'd0, a_busy}, 8'd0);
        chk("reset_flush", {7'd0, a_iff}, 8'd1);
        rst_i = 1'b1;

        // start: one edge to RUN
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("idle_pcw", {7'd0, a_pcw}, 8'd0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("run_busy_pcw", {6'd0, a_busy, a_pcw}, 8'b11);

        // load-use on rs2, then rd=x0 no stall
        cyc(1, 5'd1, 5'd5, 5'd5, 1, 0, 0);
        chk("lu_stall", {5'd0, a_pcw, a_ifw, a_idb}, 8'b001);
        cyc(1, 5'd3, 5'd0, 5'd0, 1, 0, 0);
        chk("lu_x0", {5'd0, a_pcw, a_ifw, a_idb}, 8'b110);

        // load-use suppresses branch; branch alone next cycle
        cyc(1, 5'd7, 5'd2, 5'd7, 1, 0, 1);
        chk("lu_br_sup", {4'd0, a_pcw, a_idb, a_pcs, a_iff}, 8'b0100);
        cyc(1, 5'd7, 5'd2, 5'd9, 0, 0, 1);
        chk("br_alone", {6'd0, a_pcs, a_iff}, 8'b11);

        // held mul: two stall cycles, release, then a second mul stalls again
        cyc(1, 0, 0, 0, 0, 1, 0);
        chk("mul1_s1", {6'd0, a_idw, a_exb}, 8'b01);
        chk("nomul_run", {6'd0, b_pcw, b_exb}, 8'b10);
        cyc(1, 0, 0, 0, 0, 1, 0);
        chk("mul1_s2", {6'd0, a_idw, a_exb}, 8'b01);
        cyc(1, 0, 0, 0, 0, 1, 0);
        chk("mul1_rel", {4'd0, a_pcw, a_ifw, a_idw, a_exb}, 8'b1110);
        cyc(1, 0, 0, 0, 0, 1, 0);
        chk("mul2_s1", {6'd0, a_idw, a_exb}, 8'b01);
        cyc(1, 0, 0, 0, 0, 1, 0);
        chk("mul2_s2", {6'd0, a_idw, a_exb}, 8'b01);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("mul2_rel", {6'd0, a_idw, a_exb}, 8'b10);

        // async reset in the middle of a mul stall
        cyc(1, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 1, 0);
        rst_i = 1'b0;
        #1;
        chk("rst_mid_mul", {5'd0, a_busy, a_iff, a_idb}, 8'b011);
        #3;
        rst_i = 1'b1;
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("restart", {6'd0, a_busy, a_pcw}, 8'b11);

        // stop: drain three cycles ignoring start, then IDLE
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("stop_cycle", {5'd0, a_pcw, a_iff, a_idb}, 8'b011);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0, 0, 0);
            chk("drain", {5'd0, a_busy, a_iff, a_idb}, 8'b111);
        end
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("drain_done", {7'd0, a_busy}, 8'd0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 92) ? 1'b1 : 1'b0,
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
                ($urandom_range(0, 9) < 2) ? 1'b1 : 1'b0,
                ($urandom_range(0, 9) < 2) ? 1'b1 : 1'b0);
            if ($urandom_range(0, 199) == 0) begin
                rst_i = 1'b0;
                #4;
                rst_i = 1'b1;
            end
        end

        @(posedge clk_i);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
